// File: rtl/fpu_cvt_sched.sv
// rtl/fpu_cvt_sched.sv - round-robin scheduler and 2-stage pipeline around an int-to-single converter.
// Optional define CVT_FFLAGS_EN builds the inexact (NX) flag; otherwise resp_fflags_o is tied to zero.
module fpu_cvt_sched #(
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [31:0]      req0_data_i,
  input  logic             req0_unsigned_i,
  input  logic [2:0]       req0_rm_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [31:0]      req1_data_i,
  input  logic             req1_unsigned_i,
  input  logic [2:0]       req1_rm_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  input  logic [2:0]       frm_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             resp_src_o,
  output logic             resp_illegal_o,
  output logic [4:0]       resp_fflags_o,
  output logic             busy_o
);

  logic             r_s1_v, r_s2_v, r_lrr;
  logic [31:0]      r_s1_data, r_s2_data;
  logic             r_s1_uns, r_s1_src, r_s1_ill, r_s2_src, r_s2_ill;
  logic [2:0]       r_s1_rm;
  logic [TAG_W-1:0] r_s1_tag, r_s2_tag;

  logic             w_s2_free, w_accept, w_sel1, w_fire;
  logic [2:0]       w_rm_raw, w_rm;
  logic             w_ill;

  assign w_s2_free = !r_s2_v | resp_ready_i;
  assign w_accept  = !reset_i & !flush_i & (!r_s1_v | w_s2_free);
  // Requester 1 wins a tie only when requester 0 was granted last.
  assign w_sel1    = req1_valid_i & (!req0_valid_i | !r_lrr);
  assign w_fire    = w_accept & (req0_valid_i | req1_valid_i);

  assign req0_ready_o = w_accept & req0_valid_i & !w_sel1;
  assign req1_ready_o = w_accept & w_sel1;

  assign w_rm_raw = w_sel1 ? req1_rm_i : req0_rm_i;
  assign w_rm     = (w_rm_raw == 3'b111) ? frm_i : w_rm_raw;
  assign w_ill    = (w_rm == 3'b101) | (w_rm == 3'b110);

  logic        w_sign, w_g, w_r, w_s, w_inc;
  logic [31:0] w_mag, w_norm, w_res;
  logic [4:0]  w_msb;
  logic [24:0] w_sum;
  logic [7:0]  w_exp;
  logic [22:0] w_mant;

  always_comb begin
    w_sign = !r_s1_uns & r_s1_data[31];
    w_mag  = w_sign ? (~r_s1_data + 32'd1) : r_s1_data;
    w_msb  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (w_mag[i]) w_msb = 5'(i);
    end
    w_norm = w_mag << (5'd31 - w_msb);
    w_g    = w_norm[7];
    w_r    = w_norm[6];
    w_s    = |w_norm[5:0];
    case (r_s1_rm)
      3'b000:  w_inc = w_g & (w_r | w_s | w_norm[8]);
      3'b010:  w_inc = w_sign & (w_g | w_r | w_s);
      3'b011:  w_inc = !w_sign & (w_g | w_r | w_s);
      3'b100:  w_inc = w_g;
      default: w_inc = 1'b0;
    endcase
    w_sum  = {1'b0, w_norm[31:8]} + {24'd0, w_inc};
    w_exp  = 8'd127 + {3'd0, w_msb} + {7'd0, w_sum[24]};
    w_mant = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
    w_res  = ((w_mag == 32'd0) | r_s1_ill) ? 32'd0 : {w_sign, w_exp, w_mant};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1_v    <= 1'b0;
      r_s2_v    <= 1'b0;
      r_lrr     <= 1'b1;
      r_s1_data <= '0;
      r_s1_uns  <= 1'b0;
      r_s1_rm   <= '0;
      r_s1_tag  <= '0;
      r_s1_src  <= 1'b0;
      r_s1_ill  <= 1'b0;
      r_s2_data <= '0;
      r_s2_tag  <= '0;
      r_s2_src  <= 1'b0;
      r_s2_ill  <= 1'b0;
    end else if (flush_i) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_s2_free) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_data <= w_res;
          r_s2_tag  <= r_s1_tag;
          r_s2_src  <= r_s1_src;
          r_s2_ill  <= r_s1_ill;
        end
      end
      if (w_accept) begin
        r_s1_v <= w_fire;
        if (w_fire) begin
          r_s1_data <= w_sel1 ? req1_data_i : req0_data_i;
          r_s1_uns  <= w_sel1 ? req1_unsigned_i : req0_unsigned_i;
          r_s1_tag  <= w_sel1 ? req1_tag_i : req0_tag_i;
          r_s1_rm   <= w_rm;
          r_s1_src  <= w_sel1;
          r_s1_ill  <= w_ill;
          r_lrr     <= w_sel1;
        end
      end
    end
  end

`ifdef CVT_FFLAGS_EN
  logic r_s2_nx;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s2_nx <= 1'b0;
    end else if (!flush_i && w_s2_free && r_s1_v) begin
      r_s2_nx <= !r_s1_ill & (w_g | w_r | w_s);
    end
  end
  assign resp_fflags_o = {4'b0, r_s2_nx};
`else
  assign resp_fflags_o = 5'b0;
`endif

  assign resp_valid_o   = r_s2_v;
  assign resp_data_o    = r_s2_data;
  assign resp_tag_o     = r_s2_tag;
  assign resp_src_o     = r_s2_src;
  assign resp_illegal_o = r_s2_ill;
  assign busy_o         = r_s1_v | r_s2_v;

endmodule
